// File: rtl/axi_bresp_demux.sv
// Write-response return path: steers the slave B channel to the master that owns the oldest outstanding AW.
// Latency: routing is combinational (0 cycles); an AW push becomes routable one cycle later.
// Backpressure: S_BREADY follows the selected master's BREADY; ord_full tells the AW arbiter to stop granting.
// Optional build macro DEMUX_STATUS_EN: enables sticky ovf_err / spur_err flops (tied to 0 otherwise).
module axi_bresp_demux #(
    parameter int DEPTH  = 4,
    parameter int RESP_W = 2
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              aw_push,
    input  logic              aw_sel,
    output logic              ord_full,
    output logic              ord_empty,
    input  logic              S_BVALID,
    input  logic [RESP_W-1:0] S_BRESP,
    output logic              S_BREADY,
    output logic              M0_BVALID,
    output logic [RESP_W-1:0] M0_BRESP,
    input  logic              M0_BREADY,
    output logic              M1_BVALID,
    output logic [RESP_W-1:0] M1_BRESP,
    input  logic              M1_BREADY,
    output logic              ovf_err,
    output logic              spur_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DEPTH-1:0] ord_mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             head;
    logic             pop;
    logic             push_ok;

    assign ord_empty = (count == '0);
    assign ord_full  = (count == CNT_FULL);
    assign head      = ord_mem[rd_ptr];

    always_comb begin
        S_BREADY  = 1'b0;
        M0_BVALID = 1'b0;
        M1_BVALID = 1'b0;
        M0_BRESP  = '0;
        M1_BRESP  = '0;
        if (!ord_empty) begin
            if (head) begin
                M1_BVALID = S_BVALID;
                M1_BRESP  = S_BRESP;
                S_BREADY  = M1_BREADY;
            end else begin
                M0_BVALID = S_BVALID;
                M0_BRESP  = S_BRESP;
                S_BREADY  = M0_BREADY;
            end
        end
    end

    assign pop     = S_BVALID & S_BREADY;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = aw_push & (~ord_full | pop);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count > 0.
    always_ff @(posedge ACLK) begin
        if (!ARESET && push_ok) ord_mem[wr_ptr] <= aw_sel;
    end

`ifdef DEMUX_STATUS_EN
    logic ovf_q;
    logic spur_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ovf_q  <= 1'b0;
            spur_q <= 1'b0;
        end else begin
            if (aw_push && !push_ok)   ovf_q  <= 1'b1;
            if (S_BVALID && ord_empty) spur_q <= 1'b1;
        end
    end

    assign ovf_err  = ovf_q;
    assign spur_err = spur_q;
`else
    assign ovf_err  = 1'b0;
    assign spur_err = 1'b0;
`endif

endmodule

// File: doc/axi_bresp_demux.md
# axi_bresp_demux

Write-response return path of the AXI interconnect: routes the single slave-side B channel back to whichever of two masters issued the matching AW burst. It is the counterpart of the forward-path 2:1 master select. It records each accepted AW grant in an in-order FIFO. Each B handshake pops one entry and steers S_BRESP, valid and ready to that master. The slave returns responses in AW order, so no ID matching is needed.

## Interface
- DEPTH, 4, order-FIFO entries (power of 2, ≥2); max outstanding write bursts
- RESP_W, 2, response payload width (BRESP)
- ACLK  input  1  clock, all logic rising-edge
- ARESET  input  1  synchronous reset, active-high
- aw_push  input  1  forward-path AW handshake completed this cycle
- aw_sel  input  1  master that owned that AW (0 = M0, 1 = M1)
- ord_full  output  1  FIFO holds DEPTH entries; arbiter must stop granting AW
- ord_empty  output  1  no outstanding bursts
- S_BVALID  input  1  slave response valid
- S_BRESP  input  RESP_W  slave response
- S_BREADY  output  1  ready to slave
- M0_BVALID / M1_BVALID  output  1  response valid to master 0 / 1
- M0_BRESP / M1_BRESP  output  RESP_W  response to master 0 / 1
- M0_BREADY / M1_BREADY  input  1  master ready
- ovf_err  output  1  sticky: push dropped while full (see Configuration)
- spur_err  output  1  sticky: S_BVALID seen while empty (see Configuration)

## Operation
- FIFO: DEPTH×1-bit storage, write pointer, read pointer and count (log2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- head = entry at read pointer. The routing state is derived from two things only:
  - EMPTY: count==0.
  - ROUTE_M0 / ROUTE_M1: count>0, selected by head.
- EMPTY:
  - S_BREADY=0.
  - M0_BVALID=M1_BVALID=0.
- ROUTE_Mx:
  - Mx_BVALID=S_BVALID and Mx_BRESP=S_BRESP.
  - S_BREADY=Mx_BREADY.
  - Other master: BVALID=0.
- Unselected M_BRESP outputs are driven 0.
- pop = S_BVALID & S_BREADY. It can only happen when not empty. It advances the read pointer.
- push = aw_push. It writes aw_sel at the write pointer.
  - Accepted when count<DEPTH, or when count==DEPTH and pop occurs in the same cycle.
  - Otherwise it is dropped and the count is unchanged.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - When count==1 and the push happens together with the pop, the pushed entry becomes the head next cycle.
- A push into an empty FIFO does not route in the same cycle; the first response can be routed one cycle later.
- ord_full = (count==DEPTH). ord_empty = (count==0). Both are decoded from registered count.

## Timing
- Routing is combinational from S_BVALID/S_BRESP/Mx_BREADY, with zero latency; the head is registered.
- A push in cycle N is visible as a head/count change at edge N+1.
- A pop in cycle N moves the head at edge N+1. Back-to-back B handshakes to alternating masters sustain one per cycle.
- Slave holding S_BVALID without ready: the response is held and the routing is stable, because the head does not change until the pop.
- Reset (ARESET=1 at an edge), values next cycle and regardless of activity:
  - pointers=0, count=0, ovf_err=0, spur_err=0.
  - Hence ord_empty=1, ord_full=0, S_BREADY=0, Mx_BVALID=0, Mx_BRESP=0.
  - Outstanding entries are discarded.
  - aw_push during reset is ignored.

## Configuration
- DEMUX_STATUS_EN defined:
  - ovf_err sets on a dropped push.
  - spur_err sets at an edge where S_BVALID=1 and count==0.
  - Both are sticky until ARESET.
- DEMUX_STATUS_EN undefined:
  - Both ports stay present and are tied to 0.
  - No status flops are built.
  - Routing behaviour is identical.

## Test plan
- Reset, then push sel=1 with S_BVALID=1, S_BRESP=2'b10, M1_BREADY=1 next cycle:
  - M1_BVALID=1, M1_BRESP=2'b10, S_BREADY=1, M0_BVALID=0.
  - ord_empty=1 after the edge.
- Push 0,1,0,1 back-to-back, then four responses OKAY/EXOKAY/SLVERR/DECERR with both readies=1:
  - Delivered M0,M1,M0,M1 in consecutive cycles with matching BRESP.
  - ord_full=1 after the 4th push.
- Fill DEPTH=4, then a push with no pop: dropped, count stays 4, ovf_err=1 (macro on) or 0 (macro off).
- Full FIFO, then push sel=1 together with a pop: accepted, count stays 4, and the last response is routed to M1.
- Head=M0 with M0_BREADY=0 for 3 cycles and S_BVALID held: S_BREADY=0, M1_BVALID=0, head unchanged. Raise M0_BREADY: one pop.
- Two entries outstanding, ARESET mid-response: next cycle ord_empty=1 and S_BREADY=0. S_BVALID then sets spur_err=1 (macro on).
